vram_mirror: RTL and testbench
==============================

VRAM_MIRROR -- requirements
Module: vram_mirror

Interface
REQ-001 clk_sys  input  1  system clock; every register is clocked on its rising edge.
REQ-002 reset  input  1  reset; synchronous and active-high.
REQ-003 vram_addr  input  15  video read address: bit14 selects the screen page (0 = RAM page 5, 1 = RAM page 7); bits 13:0 are the offset.
REQ-004 vid_req  input  1  video owns the memory port in this cycle.
REQ-005 vram_dout  output  8  video read data, registered.
REQ-006 cpu_wr  input  1  one-cycle CPU RAM write strobe.
REQ-007 cpu_page  input  3  RAM page being written, already resolved by the upstream mapper.
REQ-008 cpu_addr  input  14  offset within the 16 KB page.
REQ-009 cpu_din  input  8  CPU write data.
REQ-010 fifo_full  output  1  write FIFO holds 4 entries.
REQ-011 fifo_empty  output  1  write FIFO holds 0 entries.
REQ-012 ovf_cnt  output  8  count of dropped CPU writes; saturates at 255.

Function
REQ-013 The memory SHALL be a single-port array of 32768 x 8 bits, addressed as {page_sel, offset}.
REQ-014 A CPU write SHALL be mirrored only when cpu_wr=1 and cpu_page is 5 or 7.
- page 5 maps to page_sel 0; page 7 maps to page_sel 1.
- Writes to any other page SHALL be ignored.
REQ-015 A mirrored write SHALL be enqueued as {page_sel, cpu_addr, cpu_din} into a 4-entry in-order FIFO.
REQ-016 Port arbitration SHALL be decided per cycle:
- vid_req=1: read memory at vram_addr; vram_dout is valid on the next cycle.
- vid_req=0 and FIFO not empty: write the FIFO head to memory and pop it.
- otherwise: port idle; vram_dout holds its value.
REQ-017 Video SHALL always have priority; while vid_req=1, a FIFO write SHALL never reach memory.
REQ-018 Minimum latency from an accepted cpu_wr to the memory update SHALL be 1 cycle (enqueue at cycle N, drain at cycle N+1 when vid_req=0).
REQ-019 Enqueue and dequeue in the same cycle SHALL both take effect; the occupancy stays unchanged.
REQ-020 An enqueue attempted while full with no dequeue in that cycle SHALL be dropped, and ovf_cnt SHALL increment, saturating at 255.
REQ-021 An enqueue while full with a dequeue in the same cycle SHALL be accepted.
REQ-022 fifo_full and fifo_empty SHALL be registered and SHALL reflect occupancy after the current cycle's push and pop.
REQ-023 Read pointer, write pointer and occupancy SHALL wrap modulo 4, using a 3-bit count of 0..4.

Reset
REQ-024 On reset SHALL be: FIFO flushed, fifo_empty=1, fifo_full=0, ovf_cnt=0, vram_dout=0.
REQ-025 Memory contents SHALL NOT be altered by reset.
REQ-026 A reset asserted mid-drain SHALL discard all pending entries; entries already written to memory SHALL remain.
REQ-027 cpu_wr asserted in the same cycle as reset SHALL be dropped and SHALL NOT be counted.

Configuration
REQ-028 Macro VRAM_MIRROR_FWD_EN defined: a video read whose address matches a pending FIFO entry SHALL return the data of the newest matching entry instead of the memory value.
- A write enqueued in the same cycle as the read SHALL also be matched.
REQ-029 Macro VRAM_MIRROR_FWD_EN undefined: a video read SHALL return memory contents only; pending entries are invisible until drained.

Verification
REQ-030 Reset with no stimulus -> fifo_empty=1, fifo_full=0, ovf_cnt=0, vram_dout=0x00.
REQ-031 cpu_wr with page=5, addr=0x0000, data=0xA5, vid_req=0 -> FIFO drains the next cycle; then vid_req=1, vram_addr=0x0000 -> vram_dout=0xA5 one cycle later.
REQ-032 Write page=7, addr=0x1800, data=0x3C, followed by a write page=2, addr=0x1800, data=0xFF -> read of 0x5800 returns 0x3C; read of 0x1800 is unchanged; ovf_cnt=0.
REQ-033 vid_req held at 1 with 5 writes to page 5 -> fifo_full=1 after the 4th write; 5th write dropped; ovf_cnt=1; release vid_req -> 4 writes land in order within 4 cycles; fifo_empty=1.
REQ-034 vid_req held at 1 with 300 writes to page 5 -> ovf_cnt=255 (saturated).
REQ-035 Memory at 0x0010 holds 0x00; write 0x11 to page 5 offset 0x0010 with vid_req held at 1, then read 0x0010:
- with VRAM_MIRROR_FWD_EN -> vram_dout=0x11.
- without VRAM_MIRROR_FWD_EN -> vram_dout=0x00.

Source files
------------

// File: rtl/vram_mirror.sv
// Mirrors CPU writes to RAM pages 5/7 into a 32Kx8 video RAM via a 4-deep FIFO.
// Define VRAM_MIRROR_FWD_EN to let video reads see still-pending FIFO writes.
module vram_mirror (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [14:0] vram_addr,
  input  logic        vid_req,
  output logic [7:0]  vram_dout,
  input  logic        cpu_wr,
  input  logic [2:0]  cpu_page,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [7:0]  ovf_cnt
);

  typedef struct packed {
    logic        sel;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_ent_t;

  logic [7:0] mem [32768];

  wr_ent_t    fifo_q [4];
  wr_ent_t    fifo_d [4];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic [7:0] ovf_q, ovf_d;
  logic [7:0] dout_q, dout_d;

  logic       push_req;
  logic       push;
  logic       pop;
  logic       drop;
  wr_ent_t    new_ent;
  wr_ent_t    head;
  logic [7:0] rd_val;

  always_comb begin
    push_req = cpu_wr && (cpu_page == 3'd5 || cpu_page == 3'd7);
    pop      = !vid_req && (cnt_q != 3'd0);
    push     = push_req && ((cnt_q != 3'd4) || pop);
    drop     = push_req && !push;
    // page 5 = 3'b101, page 7 = 3'b111: bit 1 is the screen select
    new_ent  = '{sel: cpu_page[1], addr: cpu_addr, data: cpu_din};
    head     = fifo_q[rd_ptr_q];
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push)
      fifo_d[wr_ptr_q] = new_ent;
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};
    full_d   = (cnt_d == 3'd4);
    empty_d  = (cnt_d == 3'd0);
    ovf_d    = ovf_q;
    if (drop && ovf_q != 8'hFF)
      ovf_d = ovf_q + 8'd1;
  end

`ifdef VRAM_MIRROR_FWD_EN
  logic [1:0] idx;

  always_comb begin
    rd_val = mem[vram_addr];
    idx    = rd_ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = rd_ptr_q + 2'(i);
      if (3'(i) < cnt_q &&
          {fifo_q[idx].sel, fifo_q[idx].addr} == vram_addr)
        rd_val = fifo_q[idx].data;
    end
    if (push && {new_ent.sel, new_ent.addr} == vram_addr)
      rd_val = new_ent.data;
  end
`else
  always_comb begin
    rd_val = mem[vram_addr];
  end
`endif

  always_comb begin
    dout_d = dout_q;
    if (vid_req)
      dout_d = rd_val;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 8'd0;
      dout_q   <= 8'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage and memory are not reset; reset only discards pending drains.
  always_ff @(posedge clk_sys) begin
    fifo_q <= fifo_d;
    if (pop && !reset)
      mem[{head.sel, head.addr}] <= head.data;
  end

  assign vram_dout  = dout_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_vram_mirror.sv
// Directed self-checking bench for vram_mirror.
// Forwarding expectations follow VRAM_MIRROR_FWD_EN.
module tb_vram_mirror;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [14:0] vram_addr;
  logic        vid_req;
  logic [7:0]  vram_dout;
  logic        cpu_wr;
  logic [2:0]  cpu_page;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;

`ifdef VRAM_MIRROR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  vram_mirror dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .vram_addr  (vram_addr),
    .vid_req    (vid_req),
    .vram_dout  (vram_dout),
    .cpu_wr     (cpu_wr),
    .cpu_page   (cpu_page),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [2:0] pg, input logic [13:0] a,
                    input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_page = pg;
    cpu_addr = a;
    cpu_din  = d;
    step();
    cpu_wr   = 1'b0;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    vid_req = 1'b0;
    wr(3'd5, a, d);
    step();
  endtask

  task automatic rd(input logic [14:0] a, output logic [7:0] d);
    vid_req   = 1'b1;
    vram_addr = a;
    step();
    d         = vram_dout;
    vid_req   = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    vid_req   = 1'b0;
    vram_addr = 15'd0;
    cpu_wr    = 1'b0;
    cpu_page  = 3'd0;
    cpu_addr  = 14'd0;
    cpu_din   = 8'd0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty: got %b expected 1", fifo_empty);
    end
    checks++;
    if (fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full: got %b expected 0", fifo_full);
    end
    checks++;
    if (ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_ovf: got %0d expected 0", ovf_cnt);
    end
    checks++;
    if (vram_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h expected 00", vram_dout);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    vid_req = 1'b0;
    wr(3'd5, 14'h0000, 8'hA5);
    checks++;
    if (fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_enq: got empty=%b expected 0", fifo_empty);
    end
    step();
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: got empty=%b expected 1", fifo_empty);
    end
    rd(15'h0000, d);
    checks++;
    if (d !== 8'hA5) begin
      errors++;
      $display("FAIL basic_read: got %h expected a5", d);
    end
  endtask

  task automatic test_page_filter();
    logic [7:0] d;
    preload(14'h1800, 8'h77);
    wr(3'd7, 14'h1800, 8'h3C);
    checks++;
    if (fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL pf_enq7: got empty=%b expected 0", fifo_empty);
    end
    wr(3'd2, 14'h1800, 8'hFF);
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL pf_page2_ignored: got empty=%b expected 1", fifo_empty);
    end
    rd(15'h5800, d);
    checks++;
    if (d !== 8'h3C) begin
      errors++;
      $display("FAIL pf_read_5800: got %h expected 3c", d);
    end
    rd(15'h1800, d);
    checks++;
    if (d !== 8'h77) begin
      errors++;
      $display("FAIL pf_read_1800: got %h expected 77", d);
    end
    checks++;
    if (ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL pf_ovf: got %0d expected 0", ovf_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] exp_b [8] = '{8'h71, 8'h72, 8'h73, 8'h81,
                              8'h82, 8'h83, 8'h84, 8'h85};
    logic [14:0] adr_b [8] = '{15'h0300, 15'h0301, 15'h0302, 15'h0310,
                               15'h0311, 15'h0312, 15'h0313, 15'h0314};
    vid_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(3'd5, 14'h0300 + 14'(i), 8'h71 + 8'(i));
      checks++;
      if (fifo_empty !== 1'b0 || fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL b2b_occ%0d: got empty=%b full=%b expected 0 0",
                 i, fifo_empty, fifo_full);
      end
    end
    step();
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: got empty=%b expected 1", fifo_empty);
    end
    vid_req   = 1'b1;
    vram_addr = 15'h7000;
    for (int i = 0; i < 4; i++)
      wr(3'd5, 14'h0310 + 14'(i), 8'h81 + 8'(i));
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_fill: got full=%b expected 1", fifo_full);
    end
    vid_req = 1'b0;
    wr(3'd5, 14'h0314, 8'h85);
    checks++;
    if (fifo_full !== 1'b1 || ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_full_pushpop: got full=%b ovf=%0d expected 1 0",
               fifo_full, ovf_cnt);
    end
    repeat (4) step();
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain2: got empty=%b expected 1", fifo_empty);
    end
    for (int i = 0; i < 8; i++) begin
      rd(adr_b[i], d);
      checks++;
      if (d !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_read%0d: got %h expected %h", i, d, exp_b[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] exp_o [5] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'hEE};
    preload(14'h0104, 8'hEE);
    vid_req   = 1'b1;
    vram_addr = 15'h0000;
    for (int i = 0; i < 5; i++) begin
      wr(3'd5, 14'h0100 + 14'(i), 8'h51 + 8'(i));
      if (i == 2) begin
        checks++;
        if (fifo_full !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full3: got %b expected 0", fifo_full);
        end
      end
      if (i == 3) begin
        checks++;
        if (fifo_full !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full4: got %b expected 1", fifo_full);
        end
      end
    end
    checks++;
    if (ovf_cnt !== 8'd1 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: got ovf=%0d full=%b expected 1 1",
               ovf_cnt, fifo_full);
    end
    vid_req = 1'b0;
    repeat (3) step();
    checks++;
    if (fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain3: got empty=%b expected 0", fifo_empty);
    end
    step();
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain4: got empty=%b expected 1", fifo_empty);
    end
    for (int i = 0; i < 5; i++) begin
      rd(15'h0100 + 15'(i), d);
      checks++;
      if (d !== exp_o[i]) begin
        errors++;
        $display("FAIL ovf_read%0d: got %h expected %h", i, d, exp_o[i]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] d;
    logic [7:0] exp_r [6] = '{8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++)
      preload(14'h0200 + 14'(i), 8'h00);
    vid_req   = 1'b1;
    vram_addr = 15'h7000;
    for (int i = 0; i < 4; i++)
      wr(3'd5, 14'h0200 + 14'(i), 8'h61 + 8'(i));
    vid_req = 1'b0;
    step();
    vid_req = 1'b1;
    wr(3'd5, 14'h0204, 8'h65);
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL rst_prefull: got full=%b expected 1", fifo_full);
    end
    reset    = 1'b1;
    cpu_wr   = 1'b1;
    cpu_page = 3'd5;
    cpu_addr = 14'h0205;
    cpu_din  = 8'h99;
    step();
    reset   = 1'b0;
    cpu_wr  = 1'b0;
    vid_req = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || ovf_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_flush: got empty=%b full=%b ovf=%0d expected 1 0 0",
               fifo_empty, fifo_full, ovf_cnt);
    end
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      rd(15'h0200 + 15'(i), d);
      checks++;
      if (d !== exp_r[i]) begin
        errors++;
        $display("FAIL rst_read%0d: got %h expected %h", i, d, exp_r[i]);
      end
    end
  endtask

  task automatic test_saturate();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    vid_req   = 1'b1;
    vram_addr = 15'h0000;
    for (int i = 0; i < 258; i++)
      wr(3'd5, 14'h2000, 8'(i));
    checks++;
    if (ovf_cnt !== 8'd254) begin
      errors++;
      $display("FAIL sat_254: got %0d expected 254", ovf_cnt);
    end
    for (int i = 0; i < 42; i++)
      wr(3'd5, 14'h2000, 8'(i));
    checks++;
    if (ovf_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_255: got %0d expected 255", ovf_cnt);
    end
    vid_req = 1'b0;
    repeat (4) step();
    checks++;
    if (fifo_empty !== 1'b1 || ovf_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_drain: got empty=%b ovf=%0d expected 1 255",
               fifo_empty, ovf_cnt);
    end
  endtask

  task automatic test_fwd();
    logic [7:0] d;
    logic [7:0] e1;
    logic [7:0] e2;
    e1 = FWD ? 8'h11 : 8'h00;
    e2 = FWD ? 8'h33 : 8'h00;
    preload(14'h0010, 8'h00);
    vid_req   = 1'b1;
    vram_addr = 15'h0010;
    wr(3'd5, 14'h0010, 8'h11);
    checks++;
    if (vram_dout !== e1) begin
      errors++;
      $display("FAIL fwd_same_cycle: got %h expected %h", vram_dout, e1);
    end
    step();
    checks++;
    if (vram_dout !== e1) begin
      errors++;
      $display("FAIL fwd_pending: got %h expected %h", vram_dout, e1);
    end
    wr(3'd5, 14'h0010, 8'h33);
    step();
    checks++;
    if (vram_dout !== e2) begin
      errors++;
      $display("FAIL fwd_newest: got %h expected %h", vram_dout, e2);
    end
    vid_req = 1'b0;
    repeat (3) step();
    rd(15'h0010, d);
    checks++;
    if (d !== 8'h33 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL fwd_drained: got %h empty=%b expected 33 1",
               d, fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_page_filter();
    test_back_to_back();
    test_overflow();
    test_reset_mid_drain();
    test_saturate();
    test_fwd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
